// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLB maintenance ops (SRCH/RD/WR/FILL/INV) onto the
// TLB search-1 / read / write / invtlb ports and returns one result per op.
module tlb_op_ctrl #(
   parameter  int unsigned TLBNUM = 16,
   localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [2:0]      op_code,
   input  logic [4:0]      op_inv_op,
   input  logic [9:0]      op_asid,
   input  logic [18:0]     op_vppn,
   input  logic [IDXW-1:0] op_index,
   input  logic [18:0]     mem_vppn,
   input  logic [9:0]      mem_asid,
   output logic            mem_stall,
   output logic [18:0]     s1_vppn,
   output logic [9:0]      s1_asid,
   input  logic            s1_found,
   input  logic [IDXW-1:0] s1_index,
   output logic            invtlb_valid,
   output logic [4:0]      invtlb_op,
   output logic            we,
   output logic [IDXW-1:0] w_index,
   output logic [IDXW-1:0] r_index,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_found,
   output logic [IDXW-1:0] rsp_index,
   output logic            rsp_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   localparam logic [4:0] INV_OP_MAX = 5'd6;

   logic [1:0]      state;
   logic [1:0]      state_nx;
   logic [IDXW-1:0] fill_ctr;
   logic [IDXW-1:0] fill_nx;

   logic [2:0]      code_q;
   logic [4:0]      inv_op_q;
   logic [9:0]      asid_q;
   logic [18:0]     vppn_q;
   logic [IDXW-1:0] index_q;

   logic            accept;
   logic            acc_wr;
   logic            acc_fill;
   logic            acc_inv;
   logic            res_found;
   logic [IDXW-1:0] res_index;
   logic            res_err;

   assign accept   = (state == IDLE) && op_valid;
   assign acc_wr   = accept && (op_code == OP_WR);
   assign acc_fill = accept && (op_code == OP_FILL);
   assign acc_inv  = accept && (op_code == OP_INV) && (op_inv_op <= INV_OP_MAX);
   assign fill_nx  = fill_ctr + IDXW'(1);

   // Search port 1 is lent to the maintenance op for its single EXEC cycle
   assign s1_vppn = (state == EXEC) ? vppn_q : mem_vppn;
   assign s1_asid = (state == EXEC) ? asid_q : mem_asid;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (op_valid)  state_nx = EXEC;
         EXEC:                   state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // Free-running fill victim counter, wraps naturally at TLBNUM
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) fill_ctr <= '0;
      else         fill_ctr <= fill_nx;
   end

   // Latch the op on accept; inputs are ignored until the next accept
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         code_q   <= '0;
         inv_op_q <= '0;
         asid_q   <= '0;
         vppn_q   <= '0;
         index_q  <= '0;
      end else if (accept) begin
         code_q   <= op_code;
         inv_op_q <= op_inv_op;
         asid_q   <= op_asid;
         vppn_q   <= op_vppn;
         index_q  <= op_index;
      end
   end

   // Result of the op in EXEC; illegal ops report an error with zeroed fields
   always_comb begin
      res_found = 1'b0;
      res_index = '0;
      res_err   = 1'b0;
      case (code_q)
         OP_SRCH: begin
            res_found = s1_found;
            res_index = s1_found ? s1_index : '0;
         end
         OP_RD,
         OP_WR:   res_index = index_q;
         OP_FILL: res_index = w_index;
         OP_INV:  res_err   = (inv_op_q > INV_OP_MAX);
         default: res_err   = 1'b1;
      endcase
   end

   // Registered TLB strobes and handshake outputs, set up one edge ahead
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_ready     <= 1'b1;
         mem_stall    <= 1'b0;
         we           <= 1'b0;
         w_index      <= '0;
         r_index      <= '0;
         invtlb_valid <= 1'b0;
         invtlb_op    <= '0;
      end else begin
         op_ready     <= (state_nx == IDLE);
         mem_stall    <= (state_nx == EXEC);
         we           <= acc_wr || acc_fill;
         invtlb_valid <= acc_inv;
         if (acc_wr)        w_index <= op_index;
         else if (acc_fill) w_index <= fill_nx;
         if (acc_inv)       invtlb_op <= op_inv_op;
         if (accept && (op_code == OP_RD)) r_index <= op_index;
      end
   end

   // Response register: loaded at the end of EXEC, held until consumed
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_valid <= 1'b0;
         rsp_found <= 1'b0;
         rsp_index <= '0;
         rsp_err   <= 1'b0;
      end else if (state == EXEC) begin
         rsp_valid <= 1'b1;
         rsp_found <= res_found;
         rsp_index <= res_index;
         rsp_err   <= res_err;
      end else if ((state == RESP) && rsp_ready) begin
         rsp_valid <= 1'b0;
         rsp_found <= 1'b0;
         rsp_index <= '0;
         rsp_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed bench for tlb_op_ctrl with a small TLB model.
module tb_tlb_op_ctrl;

   localparam int unsigned TLBNUM = 16;
   localparam int unsigned IDXW   = 4;

   localparam logic [2:0] SRCH = 3'd0;
   localparam logic [2:0] RD   = 3'd1;
   localparam logic [2:0] WR   = 3'd2;
   localparam logic [2:0] FILL = 3'd3;
   localparam logic [2:0] INV  = 3'd4;

   logic            clk;
   logic            resetn;
   logic            op_valid;
   logic            op_ready;
   logic [2:0]      op_code;
   logic [4:0]      op_inv_op;
   logic [9:0]      op_asid;
   logic [18:0]     op_vppn;
   logic [IDXW-1:0] op_index;
   logic [18:0]     mem_vppn;
   logic [9:0]      mem_asid;
   logic            mem_stall;
   logic [18:0]     s1_vppn;
   logic [9:0]      s1_asid;
   logic            s1_found;
   logic [IDXW-1:0] s1_index;
   logic            invtlb_valid;
   logic [4:0]      invtlb_op;
   logic            we;
   logic [IDXW-1:0] w_index;
   logic [IDXW-1:0] r_index;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_found;
   logic [IDXW-1:0] rsp_index;
   logic            rsp_err;

   int compared   = 0;
   int mismatched = 0;

   tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .resetn(resetn),
      .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .op_inv_op(op_inv_op), .op_asid(op_asid), .op_vppn(op_vppn),
      .op_index(op_index), .mem_vppn(mem_vppn), .mem_asid(mem_asid),
      .mem_stall(mem_stall), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
      .we(we), .w_index(w_index), .r_index(r_index),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_found(rsp_found),
      .rsp_index(rsp_index), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // TLB model: entry contents come from wr_vppn/wr_asid at the write edge
   logic        ent_v    [TLBNUM] = '{default: 1'b0};
   logic [18:0] ent_vppn [TLBNUM];
   logic [9:0]  ent_asid [TLBNUM];
   logic [18:0] wr_vppn;
   logic [9:0]  wr_asid;

   always @(posedge clk) begin
      if (we) begin
         ent_v[w_index]    <= 1'b1;
         ent_vppn[w_index] <= wr_vppn;
         ent_asid[w_index] <= wr_asid;
      end
   end

   always_comb begin
      s1_found = 1'b0;
      s1_index = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         if (!s1_found && ent_v[i] && ent_vppn[i] == s1_vppn && ent_asid[i] == s1_asid) begin
            s1_found = 1'b1;
            s1_index = IDXW'(i);
         end
      end
   end

   // Strobe counters and reference fill counter
   int cyc = 0, we_cnt = 0, inv_cnt = 0;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (we)           we_cnt  = we_cnt + 1;
      if (invtlb_valid) inv_cnt = inv_cnt + 1;
   end

   logic [3:0] tb_fill;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) tb_fill <= 4'd0;
      else         tb_fill <= tb_fill + 4'd1;
   end

   // Snapshots taken during EXEC (ex_*) and the first RESP cycle (rs_*)
   int              acc_cyc, we_pulses, inv_pulses;
   logic            ex_we, ex_inv, ex_stall, ex_ready, ex_rspv;
   logic [IDXW-1:0] ex_windex, ex_rindex;
   logic [4:0]      ex_invop;
   logic [18:0]     ex_s1vppn;
   logic [9:0]      ex_s1asid;
   logic            rs_valid, rs_found, rs_err, rs_stall;
   logic [IDXW-1:0] rs_index, rs_rindex;

   task automatic issue_op(input logic [2:0] code, input logic [4:0] inv,
                           input logic [9:0] asid, input logic [18:0] vppn,
                           input logic [IDXW-1:0] idx);
      int w0, i0;
      w0 = we_cnt; i0 = inv_cnt;
      op_code = code; op_inv_op = inv; op_asid = asid; op_vppn = vppn; op_index = idx;
      op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      op_code = 3'd7; op_inv_op = 5'h1f; op_asid = '0; op_vppn = '0; op_index = '0;
      acc_cyc = cyc;
      ex_we = we; ex_windex = w_index; ex_rindex = r_index; ex_inv = invtlb_valid;
      ex_invop = invtlb_op; ex_stall = mem_stall; ex_ready = op_ready; ex_rspv = rsp_valid;
      ex_s1vppn = s1_vppn; ex_s1asid = s1_asid;
      @(posedge clk); #1;
      rs_valid = rsp_valid; rs_found = rsp_found; rs_index = rsp_index; rs_err = rsp_err;
      rs_stall = mem_stall; rs_rindex = r_index;
      we_pulses = we_cnt - w0; inv_pulses = inv_cnt - i0;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      compared++; if (op_ready !== 1'b1) begin mismatched++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
      compared++; if ({rsp_valid, rsp_found, rsp_err, rsp_index} !== 7'd0) begin mismatched++; $display("FAIL reset_rsp got %b%b%b/%h want 0", rsp_valid, rsp_found, rsp_err, rsp_index); end
      compared++; if ({we, invtlb_valid, mem_stall} !== 3'b000) begin mismatched++; $display("FAIL reset_strobes got %b want 000", {we, invtlb_valid, mem_stall}); end
      compared++; if ({w_index, r_index, invtlb_op} !== 13'd0) begin mismatched++; $display("FAIL reset_idx got %h/%h/%h want 0", w_index, r_index, invtlb_op); end
      compared++; if (s1_vppn !== 19'h00077 || s1_asid !== 10'h002) begin mismatched++; $display("FAIL reset_s1_pass got %h/%h want 00077/002", s1_vppn, s1_asid); end
      @(posedge clk); #1;
      compared++; if (op_ready !== 1'b1 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL idle_after_reset got rdy=%b v=%b want 1/0", op_ready, rsp_valid); end
   endtask

   task automatic test_write_search();
      wr_vppn = 19'h12345; wr_asid = 10'h03a;
      issue_op(WR, 5'd0, 10'h0, 19'h0, 4'd5);
      compared++; if (ex_we !== 1'b1 || ex_windex !== 4'd5) begin mismatched++; $display("FAIL wr_strobe got we=%b idx=%h want 1/5", ex_we, ex_windex); end
      compared++; if (we_pulses !== 1) begin mismatched++; $display("FAIL wr_pulse_count got %0d want 1", we_pulses); end
      compared++; if (ex_rspv !== 1'b0 || rs_valid !== 1'b1) begin mismatched++; $display("FAIL wr_latency got %b/%b want 0/1", ex_rspv, rs_valid); end
      compared++; if (rs_index !== 4'd5 || rs_found !== 1'b0 || rs_err !== 1'b0) begin mismatched++; $display("FAIL wr_rsp got %h/%b/%b want 5/0/0", rs_index, rs_found, rs_err); end
      finish_rsp();
      issue_op(SRCH, 5'd0, 10'h03a, 19'h12345, 4'd0);
      compared++; if (ex_s1vppn !== 19'h12345 || ex_s1asid !== 10'h03a) begin mismatched++; $display("FAIL srch_s1 got %h/%h want 12345/03a", ex_s1vppn, ex_s1asid); end
      compared++; if (rs_found !== 1'b1 || rs_index !== 4'd5) begin mismatched++; $display("FAIL srch_hit got %b/%h want 1/5", rs_found, rs_index); end
      compared++; if (we_pulses !== 0 || inv_pulses !== 0) begin mismatched++; $display("FAIL srch_no_strobe got %0d/%0d want 0/0", we_pulses, inv_pulses); end
      finish_rsp();
   endtask

   task automatic test_search_miss();
      compared++; if (mem_stall !== 1'b0) begin mismatched++; $display("FAIL miss_stall_idle got %b want 0", mem_stall); end
      issue_op(SRCH, 5'd0, 10'h001, 19'h55555, 4'd0);
      compared++; if (ex_stall !== 1'b1 || ex_ready !== 1'b0) begin mismatched++; $display("FAIL miss_stall_exec got %b rdy=%b want 1/0", ex_stall, ex_ready); end
      compared++; if (rs_stall !== 1'b0) begin mismatched++; $display("FAIL miss_stall_resp got %b want 0", rs_stall); end
      compared++; if (rs_valid !== 1'b1 || rs_found !== 1'b0 || rs_index !== 4'd0) begin mismatched++; $display("FAIL miss_rsp got %b/%b/%h want 1/0/0", rs_valid, rs_found, rs_index); end
      compared++; if (s1_vppn !== 19'h00077) begin mismatched++; $display("FAIL miss_s1_return got %h want 00077", s1_vppn); end
      finish_rsp();
   endtask

   task automatic test_read();
      issue_op(RD, 5'd0, 10'h0, 19'h0, 4'd9);
      compared++; if (ex_rindex !== 4'd9 || rs_rindex !== 4'd9) begin mismatched++; $display("FAIL rd_r_index got %h/%h want 9/9", ex_rindex, rs_rindex); end
      compared++; if (rs_index !== 4'd9 || rs_err !== 1'b0 || we_pulses !== 0) begin mismatched++; $display("FAIL rd_rsp got %h/%b/%0d want 9/0/0", rs_index, rs_err, we_pulses); end
      finish_rsp();
   endtask

   task automatic test_fill();
      wr_vppn = 19'h7ffff; wr_asid = 10'h3ff;
      for (int k = 0; k < 40 && tb_fill != 4'd14; k++) begin @(posedge clk); #1; end
      compared++; if (tb_fill !== 4'd14) begin mismatched++; $display("FAIL fill_wait got %h want e", tb_fill); end
      issue_op(FILL, 5'd0, 10'h0, 19'h0, 4'd2);
      compared++; if (ex_we !== 1'b1 || ex_windex !== 4'd15) begin mismatched++; $display("FAIL fill15_strobe got %b/%h want 1/f", ex_we, ex_windex); end
      compared++; if (rs_index !== 4'd15 || we_pulses !== 1) begin mismatched++; $display("FAIL fill15_rsp got %h/%0d want f/1", rs_index, we_pulses); end
      finish_rsp();
      for (int k = 0; k < 40 && tb_fill != 4'd15; k++) begin @(posedge clk); #1; end
      issue_op(FILL, 5'd0, 10'h0, 19'h0, 4'd2);
      compared++; if (ex_windex !== 4'd0 || rs_index !== 4'd0) begin mismatched++; $display("FAIL fill_wrap got %h/%h want 0/0", ex_windex, rs_index); end
      finish_rsp();
   endtask

   task automatic test_inv();
      issue_op(INV, 5'd5, 10'h003, 19'h0, 4'd0);
      compared++; if (ex_inv !== 1'b1 || ex_invop !== 5'd5) begin mismatched++; $display("FAIL inv5_strobe got %b/%h want 1/5", ex_inv, ex_invop); end
      compared++; if (inv_pulses !== 1 || rs_err !== 1'b0 || rs_index !== 4'd0) begin mismatched++; $display("FAIL inv5_rsp got %0d/%b/%h want 1/0/0", inv_pulses, rs_err, rs_index); end
      finish_rsp();
      issue_op(INV, 5'd9, 10'h003, 19'h0, 4'd0);
      compared++; if (inv_pulses !== 0 || ex_inv !== 1'b0) begin mismatched++; $display("FAIL inv9_no_pulse got %0d/%b want 0/0", inv_pulses, ex_inv); end
      compared++; if (rs_err !== 1'b1 || rs_found !== 1'b0 || rs_index !== 4'd0) begin mismatched++; $display("FAIL inv9_rsp got %b/%b/%h want 1/0/0", rs_err, rs_found, rs_index); end
      finish_rsp();
      issue_op(3'd6, 5'd0, 10'h0, 19'h0, 4'd4);
      compared++; if (rs_err !== 1'b1 || rs_index !== 4'd0 || we_pulses !== 0 || inv_pulses !== 0) begin mismatched++; $display("FAIL illegal_op got %b/%h/%0d/%0d want 1/0/0/0", rs_err, rs_index, we_pulses, inv_pulses); end
      finish_rsp();
   endtask

   task automatic test_backpressure();
      int w0;
      issue_op(RD, 5'd0, 10'h0, 19'h0, 4'd3);
      w0 = we_cnt;
      op_code = WR; op_index = 4'd2; op_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         compared++; if (rsp_valid !== 1'b1 || rsp_index !== 4'd3 || op_ready !== 1'b0) begin mismatched++; $display("FAIL bp_hold_%0d got v=%b idx=%h rdy=%b want 1/3/0", k, rsp_valid, rsp_index, op_ready); end
      end
      compared++; if (we_cnt !== w0) begin mismatched++; $display("FAIL bp_no_accept got %0d want %0d", we_cnt, w0); end
      op_valid = 1'b0;
      finish_rsp();
      compared++; if (rsp_valid !== 1'b0 || op_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", rsp_valid, op_ready); end
   endtask

   task automatic test_back_to_back();
      int a;
      issue_op(RD, 5'd0, 10'h0, 19'h0, 4'd1);
      a = acc_cyc;
      finish_rsp();
      issue_op(RD, 5'd0, 10'h0, 19'h0, 4'd2);
      compared++; if (acc_cyc - a !== 3) begin mismatched++; $display("FAIL b2b_spacing got %0d want 3", acc_cyc - a); end
      compared++; if (rs_valid !== 1'b1 || rs_index !== 4'd2) begin mismatched++; $display("FAIL b2b_rsp got %b/%h want 1/2", rs_valid, rs_index); end
      finish_rsp();
   endtask

   task automatic test_reset_mid_exec();
      int w0;
      wr_vppn = 19'h0abcd; wr_asid = 10'h011;
      w0 = we_cnt;
      op_code = WR; op_index = 4'd7; op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      resetn = 1'b0;
      #1;
      compared++; if (we !== 1'b0 || mem_stall !== 1'b0) begin mismatched++; $display("FAIL rst_exec_strobe got we=%b stall=%b want 0/0", we, mem_stall); end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      compared++; if (we_cnt !== w0) begin mismatched++; $display("FAIL rst_exec_we_count got %0d want %0d", we_cnt, w0); end
      compared++; if (op_ready !== 1'b1 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_exec_state got rdy=%b v=%b want 1/0", op_ready, rsp_valid); end
      issue_op(SRCH, 5'd0, 10'h011, 19'h0abcd, 4'd0);
      compared++; if (rs_found !== 1'b0) begin mismatched++; $display("FAIL rst_exec_no_write got %b want 0", rs_found); end
      finish_rsp();
   endtask

   initial begin
      resetn = 1'b0; op_valid = 1'b0; op_code = '0; op_inv_op = '0; op_asid = '0;
      op_vppn = '0; op_index = '0; rsp_ready = 1'b0;
      mem_vppn = 19'h00077; mem_asid = 10'h002;
      wr_vppn = '0; wr_asid = '0;
      test_reset();
      test_write_search();
      test_search_miss();
      test_read();
      test_fill();
      test_inv();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
